// File: rtl/obi_resp_tracker.sv
// -----------------------------------------------------------------------------
// obi_resp_tracker
//
// Purpose:
//   Response-side companion to the single-register OBI instruction request
//   stage. It counts granted requests that are still waiting for a response,
//   throttles new issues when MAX_OUTSTANDING are in flight, and forwards
//   memory responses to the core through one register stage. On
//   clear_pipeline, every response belonging to a request already issued is
//   silently discarded, so the core only sees responses to post-flush fetches.
//
// Handshake semantics (single point of documentation):
//   - A request is accepted on a cycle where mem_req_i & mem_gnt_i is high.
//     mem_req_i is expected to already include issue_allow_o upstream.
//   - A response is consumed on any cycle where mem_rvalid_i is high and at
//     least one request is outstanding. There is no ready on the response
//     path: the core must take core_rvalid_o/core_rdata_o on the cycle it is
//     shown. core_rvalid_o is a one-cycle pulse per delivered response.
//
// Parameters:
//   MAX_OUTSTANDING  max in-flight granted requests (1..15)
//   DATA_WIDTH       rdata width
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   clear_pipeline   flush; drops responses of all already-issued requests
//   mem_req_i        request presented to memory
//   mem_gnt_i        memory grant
//   mem_rvalid_i     memory response valid
//   mem_rdata_i      memory response data
//   core_rvalid_o    registered response valid to the core
//   core_rdata_o     registered response data to the core
//   issue_allow_o    high when another request may be granted
//   outstanding_o    current outstanding count
//
// Optional feature (macro OBI_RESP_TRACKER_ERR_EN):
//   mem_rerr_i / core_rerr_o carry a response error bit through the same
//   register and drop rules; proto_err_o is a sticky flag set on response
//   underflow or on an accept while full, cleared only by rst_i.
// -----------------------------------------------------------------------------
module obi_resp_tracker #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DATA_WIDTH      = 32,
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_pipeline,
  input  logic                  mem_req_i,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
`ifdef OBI_RESP_TRACKER_ERR_EN
  input  logic                  mem_rerr_i,
  output logic                  core_rerr_o,
  output logic                  proto_err_o,
`endif
  output logic                  core_rvalid_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic                  issue_allow_o,
  output logic [CW-1:0]         outstanding_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic accept, retire, full, accept_eff, resp_fire;

  assign accept = mem_req_i & mem_gnt_i;
  // Responses with nothing outstanding (e.g. to pre-reset requests) are ignored.
  assign retire = mem_rvalid_i & (out_cnt_q != '0);
  assign full   = (out_cnt_q == MAX_CNT);
  // An accept while full only counts if a retire frees a slot in the same cycle.
  assign accept_eff = accept & (~full | retire);

  assign out_cnt_d = out_cnt_q + CW'(accept_eff) - CW'(retire);

  // Flush reloads the drop count with everything still in flight after this
  // cycle's events, so a request accepted in the flush cycle is dropped too.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_pipeline) begin
      drop_cnt_d = out_cnt_d;
    end else if (retire && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // A response arriving in the flush cycle is dropped even if drop_cnt is 0.
  assign resp_fire = retire & (drop_cnt_q == '0) & ~clear_pipeline;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      rvalid_q   <= resp_fire;
      if (resp_fire) begin
        rdata_q <= mem_rdata_i;
      end
    end
  end

`ifdef OBI_RESP_TRACKER_ERR_EN
  logic rerr_q, proto_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rerr_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (resp_fire) begin
        rerr_q <= mem_rerr_i;
      end
      if ((mem_rvalid_i && (out_cnt_q == '0)) || (accept && full && !retire)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign core_rerr_o = rerr_q;
  assign proto_err_o = proto_err_q;
`endif

  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;
  assign issue_allow_o = ~full;
  assign outstanding_o = out_cnt_q;

endmodule

// File: tb/tb_obi_resp_tracker.sv
// -----------------------------------------------------------------------------
// tb_obi_resp_tracker
//
// Directed bench for obi_resp_tracker with MAX_OUTSTANDING = 2. Inputs are
// driven one cycle at a time by drive_cycle(); outputs are checked 1 ns after
// the active edge. Every delivered response is matched against exp_q by a
// monitor on the falling edge; a delivery with nothing expected is reported.
// -----------------------------------------------------------------------------
module tb_obi_resp_tracker;

  localparam int unsigned MAX = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = $clog2(MAX + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clear_pipeline = 1'b0;
  logic          mem_req_i = 1'b0;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          core_rvalid_o;
  logic [DW-1:0] core_rdata_o;
  logic          issue_allow_o;
  logic [CW-1:0] outstanding_o;
`ifdef OBI_RESP_TRACKER_ERR_EN
  logic mem_rerr_i = 1'b0;
  logic core_rerr_o;
  logic proto_err_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  obi_resp_tracker #(.MAX_OUTSTANDING(MAX), .DATA_WIDTH(DW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clear_pipeline (clear_pipeline),
    .mem_req_i      (mem_req_i),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
`ifdef OBI_RESP_TRACKER_ERR_EN
    .mem_rerr_i     (mem_rerr_i),
    .core_rerr_o    (core_rerr_o),
    .proto_err_o    (proto_err_o),
`endif
    .core_rvalid_o  (core_rvalid_o),
    .core_rdata_o   (core_rdata_o),
    .issue_allow_o  (issue_allow_o),
    .outstanding_o  (outstanding_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Scoreboard: every core response must match the head of exp_q.
  always @(negedge clk_i) begin
    if (!rst_i && core_rvalid_o) begin
      if (exp_q.size() == 0) check("unexpected_rvalid", core_rvalid_o, 1'b0);
      else check("rdata", core_rdata_o, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  // Apply one cycle of inputs, step past the edge, settle 1 ns.
  task automatic drive_cycle(input logic acc, input logic rv, input logic [DW-1:0] d,
                             input logic clr);
    mem_req_i      = acc;
    mem_gnt_i      = acc;
    mem_rvalid_i   = rv;
    mem_rdata_i    = d;
    clear_pipeline = clr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_outstanding", outstanding_o, 0);
    check("rst_rvalid", core_rvalid_o, 0);
    check("rst_rdata", core_rdata_o, 0);
    check("rst_allow", issue_allow_o, 1);
    rst_i = 1'b0;

    // Single fetch
    drive_cycle(1, 0, '0, 0);
    check("single_out_c1", outstanding_o, 1);
    idle();
    check("single_out_c2", outstanding_o, 1);
    exp_q.push_back(32'hDEADBEEF);
    drive_cycle(0, 1, 32'hDEADBEEF, 0);
    check("single_rvalid", core_rvalid_o, 1);
    check("single_out_c3", outstanding_o, 0);
    idle();
    check("single_rvalid_pulse", core_rvalid_o, 0);

    // Back-to-back fill, overflow ignored, retire restores allow
    drive_cycle(1, 0, '0, 0);
    check("fill_allow_1", issue_allow_o, 1);
    drive_cycle(1, 0, '0, 0);
    check("fill_out_2", outstanding_o, 2);
    check("fill_allow_0", issue_allow_o, 0);
    drive_cycle(1, 0, '0, 0);
    check("overflow_out", outstanding_o, 2);
`ifdef OBI_RESP_TRACKER_ERR_EN
    check("overflow_proto", proto_err_o, 1);
`endif
    exp_q.push_back(32'h000000A1);
    drive_cycle(0, 1, 32'h000000A1, 0);
    check("fill_allow_back", issue_allow_o, 1);
    check("fill_out_1", outstanding_o, 1);
    // Accept + retire at MAX-1 then at MAX
    drive_cycle(1, 0, '0, 0);
    exp_q.push_back(32'h000000A2);
    drive_cycle(1, 1, 32'h000000A2, 0);
    check("full_acc_ret_out", outstanding_o, 2);
    check("full_acc_ret_rdata", core_rdata_o, 32'h000000A2);
    exp_q.push_back(32'h000000A3);
    drive_cycle(0, 1, 32'h000000A3, 0);
    exp_q.push_back(32'h000000A4);
    drive_cycle(0, 1, 32'h000000A4, 0);
    check("drain_out", outstanding_o, 0);
    idle();

    // Flush with 2 outstanding
    drive_cycle(1, 0, '0, 0);
    drive_cycle(1, 0, '0, 0);
    drive_cycle(0, 0, '0, 1);
    check("flush_out", outstanding_o, 2);
    idle();
    drive_cycle(0, 1, 32'h11, 0);
    check("flush_drop_11", core_rvalid_o, 0);
    drive_cycle(0, 1, 32'h22, 0);
    check("flush_drop_22", core_rvalid_o, 0);
    check("flush_out_0", outstanding_o, 0);
    drive_cycle(1, 0, '0, 0);
    exp_q.push_back(32'h33);
    drive_cycle(0, 1, 32'h33, 0);
    check("flush_deliver_33", core_rvalid_o, 1);
    check("flush_rdata_33", core_rdata_o, 32'h33);
    idle();

    // Flush coincident with accept and response (out_cnt = 1)
    drive_cycle(1, 0, '0, 0);
    drive_cycle(1, 1, 32'h44, 1);
    check("coinc_rvalid", core_rvalid_o, 0);
    check("coinc_out", outstanding_o, 1);
    drive_cycle(1, 0, '0, 0);
    drive_cycle(0, 1, 32'h55, 0);
    check("coinc_drop_55", core_rvalid_o, 0);
    exp_q.push_back(32'h66);
    drive_cycle(0, 1, 32'h66, 0);
    check("coinc_deliver_66", core_rvalid_o, 1);
    check("coinc_out_0", outstanding_o, 0);

    // Consecutive flushes: second one retires one and reloads drop to 1
    drive_cycle(1, 0, '0, 0);
    drive_cycle(1, 0, '0, 0);
    drive_cycle(0, 0, '0, 1);
    drive_cycle(0, 1, 32'h71, 1);
    check("cons_flush_out", outstanding_o, 1);
    drive_cycle(0, 1, 32'h72, 0);
    check("cons_flush_drop", core_rvalid_o, 0);
    drive_cycle(1, 0, '0, 0);
    exp_q.push_back(32'h73);
    drive_cycle(0, 1, 32'h73, 0);
    check("cons_flush_deliver", core_rvalid_o, 1);
    idle();

    // Underflow
    drive_cycle(0, 1, 32'h77, 0);
    check("underflow_rvalid", core_rvalid_o, 0);
    check("underflow_out", outstanding_o, 0);
    check("underflow_rdata_hold", core_rdata_o, 32'h73);
`ifdef OBI_RESP_TRACKER_ERR_EN
    check("underflow_proto", proto_err_o, 1);
`endif
    idle();

    // Reset mid-operation with 2 outstanding and a response on the output
    drive_cycle(1, 0, '0, 0);
    drive_cycle(1, 0, '0, 0);
    exp_q.push_back(32'h88);
    drive_cycle(1, 1, 32'h88, 0);
    check("prerst_rvalid", core_rvalid_o, 1);
    mem_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    check("midrst_out", outstanding_o, 0);
    check("midrst_rvalid", core_rvalid_o, 0);
    check("midrst_rdata", core_rdata_o, 0);
    check("midrst_allow", issue_allow_o, 1);
`ifdef OBI_RESP_TRACKER_ERR_EN
    check("midrst_proto", proto_err_o, 0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
    drive_cycle(0, 1, 32'h91, 0);
    check("stale1_rvalid", core_rvalid_o, 0);
    drive_cycle(0, 1, 32'h92, 0);
    check("stale2_rvalid", core_rvalid_o, 0);
    check("stale_out", outstanding_o, 0);
    idle();
    idle();

    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/obi_resp_tracker.md
Name: obi_resp_tracker

Overview:
Response-side companion to the single-register OBI instruction request stage. It sits between the memory-side OBI response channel and the core's instruction fetch response. It counts granted requests still outstanding and returns responses to the core through a registered stage. On clear_pipeline it silently discards the responses of every request already issued, so that the core only sees responses to post-flush fetches.

Parameters:
MAX_OUTSTANDING, 2, maximum in-flight granted requests; legal range 1..15.
DATA_WIDTH, 32, width of rdata.

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, asynchronous, active-high
clear_pipeline  input  1  flush; same signal that clears the upstream request register
mem_req_i  input  1  req presented to memory (output of request register stage)
mem_gnt_i  input  1  memory grant
mem_rvalid_i  input  1  memory response valid
mem_rdata_i  input  DATA_WIDTH  memory response data
core_rvalid_o  output  1  registered response valid to core
core_rdata_o  output  DATA_WIDTH  registered response data to core
issue_allow_o  output  1  high when a new request may be granted; upstream ANDs it into req
outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  current outstanding count

Behaviour:
- Events, evaluated per cycle:
  - Accept: A = mem_req_i & mem_gnt_i.
  - Retire: R = mem_rvalid_i & (out_cnt != 0).
- Counters, both width CW = $clog2(MAX_OUTSTANDING+1) and reset to 0:
  - out_cnt.
  - drop_cnt, which is always <= out_cnt.
- out_cnt_nxt = out_cnt + A - R. It saturates at MAX_OUTSTANDING; an A while full is ignored.
- drop_cnt_nxt, in priority order:
  - If clear_pipeline: out_cnt_nxt. This covers all in-flight requests, including one accepted in the flush cycle, minus one retired in the flush cycle.
  - Else if R & drop_cnt != 0: drop_cnt - 1.
  - Else: unchanged.
- issue_allow_o = (out_cnt != MAX_OUTSTANDING). It is combinational, with no retire bypass.
- Response register:
  - core_rvalid_o <= R & (drop_cnt == 0) & ~clear_pipeline.
  - core_rdata_o <= mem_rdata_i whenever core_rvalid_o is being set; otherwise it holds its previous value.
  - Latency: exactly 1 cycle from mem_rvalid_i to core_rvalid_o.
- A response arriving in the flush cycle is always dropped, even if drop_cnt == 0.
- mem_rvalid_i with out_cnt == 0 (underflow) is ignored: no counter change, no core_rvalid_o.
- Simultaneous A and R at full: R frees a slot, A is counted, out_cnt stays at MAX.
- Consecutive clear_pipeline cycles: each one reloads drop_cnt from out_cnt_nxt.
- Reset, asynchronous and mid-operation: out_cnt = 0, drop_cnt = 0, core_rvalid_o = 0, core_rdata_o = 0, issue_allow_o = 1. Responses to pre-reset requests are treated as underflow and ignored.
- No FSM beyond the two counters plus the response register. core_rvalid_o is never high two cycles unless mem_rvalid_i was high two cycles.

Optional Feature:
OBI_RESP_TRACKER_ERR_EN
- Defined:
  - Adds input mem_rerr_i (1 bit).
  - Adds output core_rerr_o (1 bit), registered alongside rdata with the same drop rules and reset 0.
  - Adds output proto_err_o (1 bit), sticky, set on underflow or on an A while full; cleared only by rst_i.
- Undefined: these ports and flops are absent. Overflow and underflow are silently ignored as described above.

Test Plan:
- Single fetch:
  - Stimulus: A at cycle 0, mem_rvalid_i with rdata=0xDEADBEEF at cycle 2.
  - Required response: outstanding_o=1 in cycles 1-2, core_rvalid_o=1 with core_rdata_o=0xDEADBEEF at cycle 3, outstanding_o=0 at cycle 3.
- Back-to-back fill, MAX=2:
  - Stimulus: A in cycles 0 and 1.
  - Required response: issue_allow_o=0 from cycle 2. A retire at cycle 3 restores issue_allow_o=1 at cycle 4. Responses are delivered in order with correct data.
- Flush with 2 outstanding:
  - Stimulus: clear_pipeline at cycle 2, responses 0x11 and 0x22 at cycles 4 and 5, then a new A at cycle 6 answered with 0x33 at cycle 7.
  - Required response: core_rvalid_o stays 0 for 0x11 and 0x22. core_rvalid_o=1 with 0x33 at cycle 8.
- Flush coincident with accept and response:
  - Stimulus: out_cnt=1, then in one cycle clear_pipeline, A and mem_rvalid_i all high.
  - Required response: no core_rvalid_o, drop_cnt=1, the next response is dropped, and the one after is delivered.
- Underflow:
  - Stimulus: mem_rvalid_i with out_cnt=0.
  - Required response: core_rvalid_o stays 0, outstanding_o stays 0. With OBI_RESP_TRACKER_ERR_EN, proto_err_o=1 from the next cycle and it stays set.
- Reset mid-operation:
  - Stimulus: assert rst_i asynchronously between edges with 2 outstanding.
  - Required response: all outputs go to reset values immediately. The subsequent 2 stale responses are ignored.
